// File: rtl/lsu_wb.sv
// Load/store unit: turns one byte/halfword/word request into a single
// Wishbone classic transfer and returns extended load data.
// Misaligned or illegal-size requests complete with an error and never
// touch the bus; a bus access that is not acknowledged within
// TIMEOUT_CYCLES strobe cycles is aborted with an error.
module lsu_wb #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [29:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    // Four bits cover the default limit; wider limits get a wider counter.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 15) ? $clog2(TIMEOUT_CYCLES + 1) : 4;
    // Value the counter holds during the last permitted strobe cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             req_legal;
    logic [3:0]       sel;
    logic [31:0]      wdat_lanes;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_ext;
    logic             in_bus;

    // Legality of the incoming request: known size and natural alignment.
    always_comb begin
        req_legal = 1'b0;
        case (size_i)
            2'b00:   req_legal = 1'b1;
            2'b01:   req_legal = ~addr_i[0];
            2'b10:   req_legal = (addr_i[1:0] == 2'b00);
            default: req_legal = 1'b0;
        endcase
    end

    // Byte selects and lane-replicated store data from the latched request.
    always_comb begin
        sel        = 4'b1111;
        wdat_lanes = wdata_q;
        case (size_q)
            2'b00: begin
                sel        = 4'b0001 << addr_q[1:0];
                wdat_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                sel        = addr_q[1] ? 4'b1100 : 4'b0011;
                wdat_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                sel        = 4'b1111;
                wdat_lanes = wdata_q;
            end
        endcase
    end

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        rd_byte  = wb_dat_i[{addr_q[1:0], 3'b000} +: 8];
        rd_half  = addr_q[1] ? wb_dat_i[31:16] : wb_dat_i[15:0];
        load_ext = wb_dat_i;
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = {{16{~uns_q & rd_half[15]}}, rd_half};
            default: load_ext = wb_dat_i;
        endcase
    end

    // Next-state logic: accept in IDLE, wait for ack or timeout in BUS,
    // report for one cycle in RESP.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_i) begin
                    we_d    = we_i;
                    size_d  = size_i;
                    uns_d   = unsigned_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    err_d   = ~req_legal;
                    state_d = req_legal ? S_BUS : S_RESP;
                end
            end
            S_BUS: begin
                // An ack in the final permitted cycle still wins over timeout.
                if (wb_ack_i) begin
                    err_d   = 1'b0;
                    state_d = S_RESP;
                    if (!we_q) begin
                        rdata_d = load_ext;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any transfer in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decoded from state; bus signals are zero outside BUS.
    always_comb begin
        in_bus   = (state_q == S_BUS);
        busy_o   = in_bus;
        wb_stb_o = in_bus;
        wb_we_o  = in_bus & we_q;
        wb_sel_o = in_bus ? sel : 4'b0000;
        wb_adr_o = in_bus ? addr_q[31:2] : 30'd0;
        wb_dat_o = (in_bus && we_q) ? wdat_lanes : 32'd0;
        done_o   = (state_q == S_RESP);
        err_o    = (state_q == S_RESP) & err_q;
        rdata_o  = rdata_q;
    end

endmodule

// File: tb/tb_lsu_wb.sv
// Bench for lsu_wb: directed transactions against a word RAM slave, a
// byte-level memory model for expected values, and a per-cycle checker.
module tb_lsu_wb;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic        unsigned_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic        busy_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [29:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    lsu_wb #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .rdata_o    (rdata_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    // ---------------- RAM slave: 0 normal, 1 never ack, 2 ack in k-th strobe cycle
    logic [31:0] ram [0:255];
    int          slave_mode = 0;
    int          slave_k = 1;
    int          stb_cycles = 0;
    logic        rd_ack_q = 1'b0;
    logic [31:0] rd_data_q = 32'd0;

    assign wb_ack_i = (slave_mode == 0) ? ((wb_stb_o & wb_we_o) | rd_ack_q) :
                      (slave_mode == 2) ? (wb_stb_o && (stb_cycles == slave_k - 1)) : 1'b0;
    assign wb_dat_i = (slave_mode == 0) ? rd_data_q : ram[wb_adr_o[7:0]];

    always @(posedge clk) begin
        rd_ack_q   <= wb_stb_o & ~wb_we_o & ~rd_ack_q & (slave_mode == 0);
        rd_data_q  <= ram[wb_adr_o[7:0]];
        stb_cycles <= (wb_stb_o && !wb_ack_i) ? stb_cycles + 1 : 0;
        if (wb_stb_o && wb_we_o && wb_ack_i) begin
            for (int j = 0; j < 4; j++) begin
                if (wb_sel_o[j]) ram[wb_adr_o[7:0]][8*j +: 8] <= wb_dat_o[8*j +: 8];
            end
        end
    end

    // ---------------- behavioural model (byte-addressed memory)
    logic [7:0] model_mem [0:1023];

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic is_illegal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        return (int'(a[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] model_sel(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] s = 4'b0000;
        for (int i = 0; i < nbytes(sz); i++) s[(int'(a[1:0]) + i) % 4] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_dat(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] d = 32'd0;
        for (int j = 0; j < 4; j++) d[8*j +: 8] = wd[8*(j % nbytes(sz)) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        logic [31:0] v = 32'd0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v[8*i +: 8] = model_mem[(int'(a[9:0]) + i) % 1024];
        if (!uns && n < 4 && v[8*n-1]) begin
            for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++) model_mem[(int'(a[9:0]) + i) % 1024] = wd[8*i +: 8];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    endtask

    // ---------------- expectations for the transaction in flight
    logic        cur_we = 1'b0;
    logic [3:0]  cur_sel = 4'b0000;
    logic [29:0] cur_adr = 30'd0;
    logic [31:0] cur_dat = 32'd0;
    logic        cur_err = 1'b0;
    logic        cur_illegal = 1'b0;
    logic [31:0] cur_rdata = 32'd0;
    int          cur_stb_cnt = 0;
    logic [3:0]  last_sel = 4'b0000;
    logic [29:0] last_adr = 30'd0;
    logic [31:0] last_dat = 32'd0;
    logic [31:0] model_rdata = 32'd0;
    logic        prev_ack = 1'b0;

    // ---------------- per-cycle compare process
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                model_rdata = 32'd0;
                prev_ack    = 1'b0;
            end else begin
                check("busy_vs_stb", 32'(busy_o), 32'(wb_stb_o));
                if (prev_ack) check("stb_after_ack", 32'(wb_stb_o), 32'd0);
                if (wb_stb_o) begin
                    cur_stb_cnt++;
                    last_sel = wb_sel_o;
                    last_adr = wb_adr_o;
                    last_dat = wb_dat_o;
                    check("stb_on_illegal", 32'(cur_illegal), 32'd0);
                    check("wb_sel", 32'(wb_sel_o), 32'(cur_sel));
                    check("wb_adr", 32'(wb_adr_o), 32'(cur_adr));
                    check("wb_we", 32'(wb_we_o), 32'(cur_we));
                    if (cur_we) check("wb_dat", wb_dat_o, cur_dat);
                end
                if (done_o) begin
                    check("done_with_stb", 32'(wb_stb_o), 32'd0);
                    check("err_at_done", 32'(err_o), 32'(cur_err));
                    if (!cur_err && !cur_we) begin
                        check("load_rdata", rdata_o, cur_rdata);
                        model_rdata = cur_rdata;
                    end else begin
                        check("rdata_held", rdata_o, model_rdata);
                    end
                end else begin
                    check("err_without_done", 32'(err_o), 32'd0);
                    check("rdata_held", rdata_o, model_rdata);
                end
                prev_ack = wb_ack_i;
            end
        end
    end

    // ---------------- one request, with latency and strobe-length checks
    task automatic run_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input int mode, input int k,
                           output logic [3:0] s_sel, output logic [29:0] s_adr,
                           output logic [31:0] s_dat, output logic [31:0] s_rdata);
        logic ill;
        int   exp_lat, exp_stb, lat;
        ill         = is_illegal(sz, a);
        cur_we      = we;
        cur_sel     = model_sel(sz, a);
        cur_adr     = 30'(a >> 2);
        cur_dat     = model_dat(sz, wd);
        cur_illegal = ill;
        cur_err     = ill || (mode == 1);
        cur_rdata   = model_load(sz, uns, a);
        cur_stb_cnt = 0;
        last_sel    = 4'b0000;
        last_adr    = 30'd0;
        last_dat    = 32'd0;
        slave_mode  = mode;
        slave_k     = k;
        if (ill)            begin exp_lat = 1;     exp_stb = 0; end
        else if (mode == 1) begin exp_lat = T + 1; exp_stb = T; end
        else if (mode == 2) begin exp_lat = k + 1; exp_stb = k; end
        else if (we)        begin exp_lat = 2;     exp_stb = 1; end
        else                begin exp_lat = 3;     exp_stb = 2; end

        @(negedge clk);
        req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; wdata_i = wd;
        @(posedge clk);
        #1;
        // Scramble the inputs so any late sampling shows up.
        req_i = 1'b0; we_i = ~we; size_i = 2'b11; unsigned_i = ~uns; addr_i = ~a; wdata_i = ~wd;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done_o) begin
                lat = c;
                break;
            end
        end
        s_rdata = rdata_o;
        @(posedge clk);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_stb_cycles"}, 32'(cur_stb_cnt), 32'(exp_stb));
        s_sel = last_sel;
        s_adr = last_adr;
        s_dat = last_dat;
        if (!ill && we && mode != 1) model_store(sz, a, wd);
        slave_mode = 0;
        $display("txn %-8s we=%0d size=%0d addr=0x%08h lat=%0d stb=%0d err_exp=%0d rdata=0x%08h",
                 tag, we, sz, a, lat, cur_stb_cnt, cur_err, s_rdata);
    endtask

    // ---------------- directed sequence
    initial begin
        logic [3:0]  sel;
        logic [29:0] adr;
        logic [31:0] dat, rd;

        for (int i = 0; i < 256; i++) ram[i] = 32'd0;
        for (int i = 0; i < 1024; i++) model_mem[i] = 8'd0;

        // Reset state
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_sel", 32'(wb_sel_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;

        run_req("st_w", 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0, 0, sel, adr, dat, rd);
        check("st_w_sel", 32'(sel), 32'hF);
        check("st_w_adr", 32'(adr), 32'h40);
        check("st_w_dat", dat, 32'hDEADBEEF);
        run_req("ld_w", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0, sel, adr, dat, rd);
        check("ld_w_sel", 32'(sel), 32'hF);
        check("ld_w_rdata", rd, 32'hDEADBEEF);
        run_req("st_b", 1'b1, 2'd0, 1'b0, 32'h103, 32'h80, 0, 0, sel, adr, dat, rd);
        check("st_b_sel", 32'(sel), 32'h8);
        check("st_b_dat", dat, 32'h80808080);
        run_req("ld_sb", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 0, sel, adr, dat, rd);
        check("ld_sb_rdata", rd, 32'hFFFFFF80);
        run_req("ld_ub", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 0, sel, adr, dat, rd);
        check("ld_ub_rdata", rd, 32'h00000080);
        run_req("st_h", 1'b1, 2'd1, 1'b0, 32'h102, 32'h8001, 0, 0, sel, adr, dat, rd);
        check("st_h_sel", 32'(sel), 32'hC);
        check("st_h_dat", dat, 32'h80018001);
        run_req("ld_sh", 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 0, 0, sel, adr, dat, rd);
        check("ld_sh_rdata", rd, 32'hFFFF8001);
        run_req("ld_uh", 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 0, 0, sel, adr, dat, rd);
        check("ld_uh_rdata", rd, 32'h00008001);
        run_req("ld_w2", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0, sel, adr, dat, rd);
        check("ld_w2_rdata", rd, 32'h8001BEEF);
        run_req("st_b1", 1'b1, 2'd0, 1'b0, 32'h101, 32'h5A, 0, 0, sel, adr, dat, rd);
        check("st_b1_sel", 32'(sel), 32'h2);
        check("st_b1_dat", dat, 32'h5A5A5A5A);
        run_req("ld_w3", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0, sel, adr, dat, rd);
        check("ld_w3_rdata", rd, 32'h80015AEF);

        // Alignment and size errors: done+err in cycle 1, no strobe
        run_req("err_h", 1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 0, 0, sel, adr, dat, rd);
        run_req("err_w", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0, 0, sel, adr, dat, rd);
        run_req("err_sz", 1'b1, 2'd3, 1'b0, 32'h100, 32'h1234, 0, 0, sel, adr, dat, rd);

        // Timeout keeps old rdata; ack in the last permitted cycle succeeds
        run_req("ld_ub2", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 0, sel, adr, dat, rd);
        run_req("to_ld", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1, 0, sel, adr, dat, rd);
        check("to_ld_rdata", rd, 32'h00000080);
        run_req("late_ld", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 2, T, sel, adr, dat, rd);
        check("late_ld_rdata", rd, 32'h80015AEF);

        // Reset while a load strobe is high
        cur_we = 1'b0; cur_sel = 4'hF; cur_adr = 30'h40; cur_illegal = 1'b0; cur_err = 1'b0;
        cur_dat = 32'd0; cur_rdata = model_load(2'd2, 1'b0, 32'h100); slave_mode = 0;
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; unsigned_i = 1'b0; addr_i = 32'h100;
        @(posedge clk);
        #1 req_i = 1'b0;
        @(negedge clk);
        check("rst_mid_stb_before", 32'(wb_stb_o), 32'd1);
        rst_i = 1'b0;
        model_rdata = 32'd0;
        prev_ack = 1'b0;
        #1;
        check("rst_mid_stb", 32'(wb_stb_o), 32'd0);
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_done", 32'(done_o), 32'd0);
        check("rst_mid_rdata", rdata_o, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rst_no_done", 32'(done_o), 32'd0);
        end
        $display("txn %-8s reset during load strobe", "rst_mid");
        run_req("post_rst", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0, sel, adr, dat, rd);
        check("post_rst_rdata", rd, 32'h80015AEF);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global bound on run time
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish within bound");
        $fatal(1);
    end

endmodule
